// File: rtl/fap80_vram_pkg.sv
// Shared constants and state encoding for the back-to-front VRAM copier.
package fap80_vram_pkg;
  localparam int VRAM_BYTES = 4800;
  localparam int ATTR_BASE  = 0;
  localparam int CHAR_BASE  = 2400;
  localparam int ADDR_W     = 13;

  typedef enum logic [2:0] {
    S_IDLE, S_ARMED, S_READ, S_LATCH, S_WRITE, S_RELEASE, S_DONE
  } state_t;
endpackage

// File: rtl/vblank_sync.sv
// Brings the scanner's vblank into clk50 and flags its rising edge.
module vblank_sync (
  input  logic clk50,
  input  logic clr_n,
  input  logic vblank,
  output logic vb_s,
  output logic vb_rise
);
  logic meta, vb_d;

  always_ff @(posedge clk50) begin
    if (!clr_n) begin
      meta <= 1'b0;
      vb_s <= 1'b0;
      vb_d <= 1'b0;
    end else begin
      meta <= vblank;
      vb_s <= meta;
      vb_d <= vb_s;
    end
  end

  assign vb_rise = vb_s & ~vb_d;
endmodule

// File: rtl/vram_copier.sv
// Copies back VRAM into front VRAM during vblank, 4 cycles per byte,
// suspending at blank end and resuming at the same byte next frame.
module vram_copier #(
  parameter int VRAM_BYTES = fap80_vram_pkg::VRAM_BYTES,
  parameter int ADDR_W     = fap80_vram_pkg::ADDR_W
) (
  input  logic              clk50,
  input  logic              clr_n,
  input  logic              vblank,
  input  logic              copy_req,
  output logic [ADDR_W-1:0] back_vram_addr,
  output logic              back_vram_rd_n,
  input  logic [7:0]        back_vram_din,
  output logic [ADDR_W-1:0] front_vram_addr,
  output logic [7:0]        front_vram_dout,
  output logic              front_vram_wr_n,
  output logic              front_bus_en,
  output logic              busy,
  output logic              done
);
  import fap80_vram_pkg::*;

  localparam logic [ADDR_W-1:0] LAST  = ADDR_W'(VRAM_BYTES - 1);
  localparam logic [ADDR_W-1:0] FIRST = ADDR_W'(ATTR_BASE);

  state_t            state, state_nx;
  logic [ADDR_W-1:0] cnt, cnt_nx;
  logic [7:0]        hold;
  logic              pend, pend_nx;
  logic              vb_s, vb_rise;

  vblank_sync u_sync (
    .clk50   (clk50),
    .clr_n   (clr_n),
    .vblank  (vblank),
    .vb_s    (vb_s),
    .vb_rise (vb_rise)
  );

  always_ff @(posedge clk50) begin
    if (!clr_n) begin
      state <= S_IDLE;
      cnt   <= '0;
      pend  <= 1'b0;
      hold  <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      pend  <= pend_nx;
      if (state == S_LATCH) hold <= back_vram_din;
    end
  end

  // pend only clears when a fresh copy is armed; a suspend re-enters ARMED
  // mid-copy and must not drop a request queued behind the running copy.
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    pend_nx  = pend | (copy_req & (state != S_IDLE));
    unique case (state)
      S_IDLE: if (copy_req) begin
        state_nx = S_ARMED;
        cnt_nx   = FIRST;
        pend_nx  = 1'b0;
      end
      S_ARMED:   if (vb_rise) state_nx = S_READ;
      S_READ:    state_nx = S_LATCH;
      S_LATCH:   state_nx = S_WRITE;
      S_WRITE:   state_nx = S_RELEASE;
      S_RELEASE: begin
        if (cnt == LAST) state_nx = S_DONE;
        else begin
          cnt_nx   = cnt + ADDR_W'(1);
          state_nx = vb_s ? S_READ : S_ARMED;
        end
      end
      S_DONE: begin
        if (pend | copy_req) begin
          state_nx = S_ARMED;
          cnt_nx   = FIRST;
          pend_nx  = 1'b0;
        end else state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    busy            = (state != S_IDLE);
    done            = (state == S_DONE);
    back_vram_rd_n  = ~((state == S_READ) | (state == S_LATCH));
    back_vram_addr  = back_vram_rd_n ? '0 : cnt;
    front_vram_wr_n = (state != S_WRITE);
    front_bus_en    = (state == S_WRITE) | (state == S_RELEASE);
    front_vram_addr = front_bus_en ? cnt : '0;
    front_vram_dout = front_bus_en ? hold : '0;
  end
endmodule

// File: tb/tb_vram_copier.sv
// Bench for vram_copier: cycle vectors for start-up, then randomized
// frame-level copies checked against a byte-array model of both VRAMs.
module tb_vram_copier;
  localparam int NB = 4800;
  localparam int AW = 13;

  logic          clk50 = 1'b0, clr_n = 1'b0, vblank = 1'b0, copy_req = 1'b0;
  logic [AW-1:0] back_vram_addr, front_vram_addr;
  logic          back_vram_rd_n, front_vram_wr_n, front_bus_en, busy, done;
  logic [7:0]    back_vram_din = '0;
  logic [7:0]    front_vram_dout;

  logic [7:0] back_mem  [NB];
  logic [7:0] front_mem [NB];
  int checks = 0, errors = 0, cyc = 0;
  int exp_idx = 0, done_cnt = 0, wcount = 0;
  bit mon_en = 0, prev_done = 0;

  typedef struct {
    logic clr_n, vb, req;
    logic busy, rd_n, wr_n, en, done;
    int   baddr;
  } vec_t;
  vec_t tbl [10];

  vram_copier #(.VRAM_BYTES(NB), .ADDR_W(AW)) dut (
    .clk50(clk50), .clr_n(clr_n), .vblank(vblank), .copy_req(copy_req),
    .back_vram_addr(back_vram_addr), .back_vram_rd_n(back_vram_rd_n),
    .back_vram_din(back_vram_din), .front_vram_addr(front_vram_addr),
    .front_vram_dout(front_vram_dout), .front_vram_wr_n(front_vram_wr_n),
    .front_bus_en(front_bus_en), .busy(busy), .done(done)
  );

  always #5 clk50 = ~clk50;
  always @(posedge clk50) cyc <= cyc + 1;

  // back VRAM: synchronous read while rd_n is low
  always @(posedge clk50)
    if (back_vram_rd_n === 1'b0 && int'(back_vram_addr) < NB)
      back_vram_din <= back_mem[back_vram_addr];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s got %0d want %0d", nm, act, expv);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk50);
  endtask

  // Every front write must be the next byte in order, carrying back VRAM data.
  task automatic monitor();
    forever begin
      @(negedge clk50);
      if (mon_en) begin
        if (!clr_n) exp_idx = 0;
        else begin
          if (front_vram_wr_n === 1'b0) begin
            checks++;
            wcount++;
            if (front_bus_en !== 1'b1 || exp_idx >= NB || int'(front_vram_addr) != exp_idx ||
                front_vram_dout !== back_mem[exp_idx]) begin
              errors++;
              $display("FAIL write addr %0d data %0h want addr %0d", front_vram_addr,
                       front_vram_dout, exp_idx);
            end
            if (int'(front_vram_addr) < NB) front_mem[front_vram_addr] = front_vram_dout;
            exp_idx++;
          end
          if (front_bus_en !== 1'b1) begin
            checks++;
            if (front_vram_addr !== '0 || front_vram_dout !== '0) begin
              errors++;
              $display("FAIL idle bus addr %0d data %0h want 0", front_vram_addr, front_vram_dout);
            end
          end
          if (done === 1'b1) begin
            checks++;
            done_cnt++;
            if (prev_done || exp_idx != NB) begin
              errors++;
              $display("FAIL done bytes %0d repeat %0d want %0d once", exp_idx, prev_done, NB);
            end
            exp_idx = 0;
          end
        end
        prev_done = (done === 1'b1);
      end
    end
  endtask

  initial begin
    int t_read, n, mism, d0, wc0, f, first_frames, used, g;
    for (int a = 0; a < NB; a++) begin
      back_mem[a]  = 8'(a % 256) ^ 8'h5A;
      front_mem[a] = ~back_mem[a];
    end
    //            clr vb req  busy rd wr en done baddr
    tbl[0] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 0};
    tbl[1] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 0};
    tbl[2] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 0};
    tbl[3] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 0};
    tbl[4] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 0};
    tbl[5] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 0};
    tbl[6] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 0};
    tbl[7] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 0};
    tbl[8] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 0};
    tbl[9] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1};
    fork monitor(); join_none

    // start-up vectors: reset, request, raw vblank edge, first two bytes
    t_read = 0;
    @(negedge clk50);
    for (int i = 0; i < 10; i++) begin
      clr_n = tbl[i].clr_n; vblank = tbl[i].vb; copy_req = tbl[i].req;
      tick(1);
      if (i == 0) mon_en = 1;
      if (i == 5) t_read = cyc;
      chk($sformatf("vec%0d busy", i), busy, tbl[i].busy);
      chk($sformatf("vec%0d rd_n", i), back_vram_rd_n, tbl[i].rd_n);
      chk($sformatf("vec%0d wr_n", i), front_vram_wr_n, tbl[i].wr_n);
      chk($sformatf("vec%0d bus_en", i), front_bus_en, tbl[i].en);
      chk($sformatf("vec%0d done", i), done, tbl[i].done);
      chk($sformatf("vec%0d back_addr", i), back_vram_addr, tbl[i].baddr);
    end

    // full copy in one long blank
    n = 0;
    while (done !== 1'b1 && n < 25000) begin tick(1); n++; end
    chk("t1 done latency", cyc - t_read, 19200);
    tick(1);
    chk("t1 busy after done", busy, 0);
    chk("t1 done count", done_cnt, 1);
    mism = 0;
    for (int a = 0; a < NB; a++) if (front_mem[a] !== back_mem[a]) mism++;
    chk("t1 front mismatches", mism, 0);
    chk("t1 front[0]", front_mem[0], (0 % 256) ^ 90);
    chk("t1 front[2399]", front_mem[2399], (2399 % 256) ^ 90);
    chk("t1 front[2400]", front_mem[2400], (2400 % 256) ^ 90);
    chk("t1 front[4799]", front_mem[4799], (4799 % 256) ^ 90);

    // short blanks force suspend/resume; three requests merge into one more copy
    vblank = 0;
    tick(20);
    for (int a = 0; a < NB; a++) begin
      back_mem[a]  = 8'($urandom);
      front_mem[a] = ~back_mem[a];
    end
    d0 = done_cnt; wc0 = wcount;
    copy_req = 1; tick(1); copy_req = 0; tick(10);
    first_frames = 0; f = 0;
    while (done_cnt < d0 + 2 && f < 8) begin
      vblank = 1; used = 0;
      if (f == 0)
        for (int k = 0; k < 3; k++) begin
          g = int'($urandom_range(5, 60));
          tick(g); copy_req = 1; tick(1); copy_req = 0;
          used += g + 1;
        end
      tick(8000 - used);
      vblank = 0;
      if (first_frames == 0 && done_cnt > d0) first_frames = f + 1;
      tick(int'($urandom_range(300, 700)));
      f++;
    end
    chk("t2 frames for first copy", first_frames, 3);
    chk("t2 done pulses", done_cnt - d0, 2);
    chk("t2 write count", wcount - wc0, 2 * NB);
    mism = 0;
    for (int a = 0; a < NB; a++) if (front_mem[a] !== back_mem[a]) mism++;
    chk("t2 front mismatches", mism, 0);
    vblank = 1; tick(1000); vblank = 0; tick(10);
    chk("t2 busy after merge", busy, 0);
    chk("t2 no extra copy", done_cnt - d0, 2);

    // reset while byte 1000 is being written
    copy_req = 1; tick(1); copy_req = 0; tick(5);
    vblank = 1;
    n = 0;
    while (!(front_vram_wr_n === 1'b0 && int'(front_vram_addr) == 1000) && n < 6000) begin
      tick(1); n++;
    end
    chk("t4 write of byte 1000", front_vram_addr, 1000);
    d0 = done_cnt;
    clr_n = 0; tick(1);
    chk("t4 wr_n after reset", front_vram_wr_n, 1);
    chk("t4 busy after reset", busy, 0);
    chk("t4 bus_en after reset", front_bus_en, 0);
    chk("t4 rd_n after reset", back_vram_rd_n, 1);
    tick(1); clr_n = 1; wc0 = wcount;
    vblank = 0; tick(20); vblank = 1; tick(100);
    chk("t4 stays idle", busy, 0);
    chk("t4 bus_en idle", front_bus_en, 0);
    chk("t4 no writes", wcount - wc0, 0);
    chk("t4 no done", done_cnt - d0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
